ex_muldiv_ctrl: RTL and testbench
=================================

EX_MULDIV_CTRL -- requirements
Module: ex_muldiv_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, operand and HI/LO width.
REQ-002 SHALL have parameter CNT_SIZE, default 6, iteration counter width.
REQ-003 SHALL have port i_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port i_reset  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_start  in  1  op request from EX stage, operands already post-forwarding.
REQ-006 SHALL have port i_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 SHALL have port i_data_a  in  DATA_SIZE  rs operand: multiplicand or dividend.
REQ-008 SHALL have port i_data_b  in  DATA_SIZE  rt operand: multiplier or divisor.
REQ-009 SHALL have port i_flush  in  1  abort in-flight op (branch/jump squash).
REQ-010 SHALL have port o_busy  out  1  op in flight; hazard unit stalls MFHI/MFLO/new mul-div on it.
REQ-011 SHALL have port o_done  out  1  one-cycle pulse, HI/LO valid this cycle.
REQ-012 SHALL have port o_hi  out  DATA_SIZE  HI register: product high word or remainder.
REQ-013 SHALL have port o_lo  out  DATA_SIZE  LO register: product low word or quotient.
REQ-014 SHALL have port o_div_by_zero  out  1  last completed op was a divide by zero.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, FIXUP, DONE; all outputs registered.
REQ-016 SHALL accept i_start only in IDLE; i_start in CALC/FIXUP/DONE ignored.
REQ-017 On accept (cycle T) SHALL latch operand magnitudes (two's-complement negate if signed op and MSB=1), result signs, op, clear counter, clear o_div_by_zero, enter CALC at T+1.
REQ-018 Magnitude of 0x80000000 SHALL be 0x80000000 treated as unsigned.
REQ-019 CALC SHALL run exactly 32 iterations, one per cycle (T+1..T+32): shift-add for multiply, restoring shift-subtract for divide, into 2*DATA_SIZE working register.
REQ-020 After 32nd iteration SHALL enter FIXUP (T+33): negate 64-bit product if operand signs differ (MULT); negate quotient if signs differ and remainder if dividend negative (DIV); unsigned ops pass through.
REQ-021 SHALL write o_hi/o_lo and pulse o_done in DONE (T+34), then return to IDLE at T+35.
REQ-022 o_busy SHALL be 1 in CALC and FIXUP only (T+1..T+33); 0 in IDLE and DONE.
REQ-023 DIV/DIVU with i_data_b=0 SHALL skip CALC/FIXUP: DONE at T+1, o_hi=i_data_a, o_lo=all-ones, o_div_by_zero=1; o_busy stays 0.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0 (wrap, no trap).
REQ-025 o_hi/o_lo SHALL change only in DONE; hold value otherwise.
REQ-026 o_div_by_zero SHALL hold until next accepted i_start.
REQ-027 i_flush in any state SHALL force IDLE next cycle, o_busy=0, no o_done, HI/LO unchanged; i_flush with i_start in IDLE: start ignored.
REQ-028 Priority SHALL be i_reset > i_flush > i_start.

Reset
REQ-029 i_reset=1 at edge SHALL give state IDLE, counter 0, o_busy=0, o_done=0, o_hi=0, o_lo=0, o_div_by_zero=0, regardless of state; mid-operation results discarded.
REQ-030 i_start coincident with i_reset SHALL be ignored.

Verification
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF, start T -> o_busy 1 T+1..T+33, o_done T+34, HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 MULT 0xFFFFFFFD (-3) x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB at T+34.
REQ-033 DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-034 DIVU 0x64 / 0 -> o_done T+1, o_busy never 1, HI=0x64, LO=0xFFFFFFFF, o_div_by_zero=1 until next start.
REQ-035 MULTU start T, i_flush T+10 -> o_busy 0 at T+11, no o_done, HI/LO keep prior values; new start T+11 accepted.
REQ-036 DIV start T, i_reset T+20 -> T+21 all outputs 0, IDLE; i_start during reset cycle ignored.

Source files
------------

// File: rtl/ex_muldiv_ctrl.sv
// Iterative multiply/divide unit for the EX stage: 32-cycle shift-add multiply,
// restoring divide, sign fixup, and HI/LO result registers.
module ex_muldiv_ctrl #(
  parameter int DATA_SIZE = 32,
  parameter int CNT_SIZE  = 6
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [1:0]           i_op,
  input  logic [DATA_SIZE-1:0] i_data_a,
  input  logic [DATA_SIZE-1:0] i_data_b,
  input  logic                 i_flush,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [DATA_SIZE-1:0] o_hi,
  output logic [DATA_SIZE-1:0] o_lo,
  output logic                 o_div_by_zero
);

  localparam int W = DATA_SIZE;
  localparam logic [CNT_SIZE-1:0] LAST = CNT_SIZE'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic [CNT_SIZE-1:0] cnt;
  logic [2*W-1:0]      acc;
  logic [W-1:0]        mag_b;
  logic                is_div;
  logic                neg_q;
  logic                neg_r;

  logic load;
  logic step;
  logic write_res;
  logic write_dbz;

  // Operand decode at accept time (op[0]=1 means unsigned, op[1]=1 means divide)
  logic           op_signed;
  logic           op_div_in;
  logic           a_neg;
  logic           b_neg;
  logic [W-1:0]   mag_a_in;
  logic [W-1:0]   mag_b_in;
  logic           div_zero;

  assign op_signed = ~i_op[0];
  assign op_div_in = i_op[1];
  assign a_neg     = op_signed & i_data_a[W-1];
  assign b_neg     = op_signed & i_data_b[W-1];
  assign mag_a_in  = a_neg ? -i_data_a : i_data_a;
  assign mag_b_in  = b_neg ? -i_data_b : i_data_b;
  assign div_zero  = op_div_in & (i_data_b == '0);

  // One iteration: multiply keeps {partial, multiplier} and shifts right;
  // divide keeps {remainder, dividend/quotient} and shifts left.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     rem_shift;
  logic [W:0]     div_diff;
  logic [2*W-1:0] div_next;

  assign mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_b} : {(W+1){1'b0}});
  assign mul_next  = {mul_sum, acc[W-1:1]};
  assign rem_shift = acc[2*W-1:W-1];
  assign div_diff  = rem_shift - {1'b0, mag_b};
  assign div_next  = div_diff[W] ? {rem_shift[W-1:0], acc[W-2:0], 1'b0}
                                 : {div_diff[W-1:0], acc[W-2:0], 1'b1};

  logic [W-1:0]   fix_hi;
  logic [W-1:0]   fix_lo;
  logic [2*W-1:0] prod_fix;

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    if (is_div) begin
      fix_lo = neg_q ? -acc[W-1:0] : acc[W-1:0];
      fix_hi = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
    end else begin
      fix_lo = prod_fix[W-1:0];
      fix_hi = prod_fix[2*W-1:W];
    end
  end

  // i_start is a request, not a handshake: it is taken only when the unit is
  // IDLE and no flush is present; o_busy is what the hazard unit stalls on.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    write_res  = 1'b0;
    write_dbz  = 1'b0;
    if (i_flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            if (div_zero) begin
              state_next = DONE;
              write_dbz  = 1'b1;
            end else begin
              state_next = CALC;
              load       = 1'b1;
            end
          end
        end
        CALC: begin
          step = 1'b1;
          if (cnt == LAST) state_next = FIXUP;
        end
        FIXUP: begin
          state_next = DONE;
          write_res  = 1'b1;
        end
        DONE: begin
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      cnt           <= '0;
      acc           <= '0;
      mag_b         <= '0;
      is_div        <= 1'b0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_hi          <= '0;
      o_lo          <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      state  <= state_next;
      o_busy <= (state_next == CALC) || (state_next == FIXUP);
      o_done <= (state_next == DONE);
      if (load) begin
        cnt           <= '0;
        acc           <= {{W{1'b0}}, mag_a_in};
        mag_b         <= mag_b_in;
        is_div        <= op_div_in;
        neg_q         <= a_neg ^ b_neg;
        neg_r         <= a_neg;
        o_div_by_zero <= 1'b0;
      end else if (step) begin
        cnt <= cnt + 1'b1;
        acc <= is_div ? div_next : mul_next;
      end
      if (write_res) begin
        o_hi <= fix_hi;
        o_lo <= fix_lo;
      end
      if (write_dbz) begin
        cnt           <= '0;
        o_hi          <= i_data_a;
        o_lo          <= '1;
        o_div_by_zero <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Bench for ex_muldiv_ctrl: directed corner cases plus random ops scored
// against a 64-bit arithmetic reference model.
module tb_ex_muldiv_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         flush;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         dbz;

  ex_muldiv_ctrl #(.DATA_SIZE(W), .CNT_SIZE(6)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_op(op),
    .i_data_a(a), .i_data_b(b), .i_flush(flush),
    .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo), .o_div_by_zero(dbz)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_pass   = 0;
  string        cur      = "init";
  logic [W-1:0] prev_hi  = '0;
  logic [W-1:0] prev_lo  = '0;
  logic [2*W:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s/%s: got %0h expected %0h", cur, tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {div_by_zero, hi, lo} from plain 64-bit arithmetic
  function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    longint          sx, sy, r64;
    longint unsigned ux, uy, u64;
    logic [63:0]     res;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    res = '0;
    case (o)
      2'd0: begin r64 = sx * sy; res = r64; end
      2'd1: begin u64 = ux * uy; res = u64; end
      2'd2: begin
        if (y == 0) return {1'b1, x, {W{1'b1}}};
        r64 = sx / sy; res[31:0]  = r64[31:0];
        r64 = sx % sy; res[63:32] = r64[31:0];
      end
      default: begin
        if (y == 0) return {1'b1, x, {W{1'b1}}};
        u64 = ux / uy; res[31:0]  = u64[31:0];
        u64 = ux % uy; res[63:32] = u64[31:0];
      end
    endcase
    return {1'b0, res};
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int poke_k);
    logic [2*W:0] e;
    int           lat;
    int           done_cyc = 0;
    int           busy_err = 0;
    int           hold_err = 0;
    logic [W-1:0] got_hi = 'x;
    logic [W-1:0] got_lo = 'x;
    logic         got_dbz = 1'bx;
    logic         done_after = 1'bx;
    logic         exp_busy;
    exp_q.push_back(model(o, x, y));
    lat = (o[1] && y == 0) ? 1 : 34;
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0; a = $urandom; b = $urandom;
    for (int k = 1; k <= lat + 1; k++) begin
      if (k > 1) begin
        start = 1'b0;
        tick();
      end
      exp_busy = (lat == 34) && (k <= 33);
      if (busy !== exp_busy) busy_err++;
      if (k < lat && (hi !== prev_hi || lo !== prev_lo)) hold_err++;
      if (done === 1'b1 && done_cyc == 0) begin
        done_cyc = k; got_hi = hi; got_lo = lo; got_dbz = dbz;
      end
      if (k == lat + 1) done_after = done;
      if (k == poke_k) begin
        start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
      end
    end
    start = 1'b0;
    e = exp_q.pop_front();
    check("latency", done_cyc, lat);
    check("busy", busy_err, 0);
    check("hold", hold_err, 0);
    check("hi", got_hi, e[63:32]);
    check("lo", got_lo, e[31:0]);
    check("dbz", got_dbz, e[64]);
    check("done_pulse", done_after, 1'b0);
    prev_hi = e[63:32];
    prev_lo = e[31:0];
  endtask

  task automatic flush_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int fk);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (fk - 1) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("busy_after_flush", busy, 1'b0);
    check("done_after_flush", done, 1'b0);
    check("hi_after_flush", hi, prev_hi);
    check("lo_after_flush", lo, prev_lo);
    tick();
    check("done_late", done, 1'b0);
    check("busy_late", busy, 1'b0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return '1;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    #1;
    repeat (2) tick();
    start = 1'b1; op = 2'd1; a = 32'd5; b = 32'd5;
    tick();
    rst = 1'b0; start = 1'b0;
    cur = "reset";
    check("busy", busy, 1'b0);
    check("done", done, 1'b0);
    check("hi", hi, '0);
    check("lo", lo, '0);
    check("dbz", dbz, 1'b0);
    tick();
    check("busy_start_in_reset", busy, 1'b0);

    cur = "multu_max";   run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    cur = "mult_neg";    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0);
    cur = "div_neg";     run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    cur = "divu_small";  run_op(2'd3, 32'd7, 32'd2, 0);
    cur = "div_wrap";    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    cur = "mult_minint"; run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 0);
    cur = "divu_zero";   run_op(2'd3, 32'h64, 32'd0, 0);
    repeat (3) tick();
    check("dbz_hold", dbz, 1'b1);
    cur = "div_zero_neg"; run_op(2'd2, 32'hFFFF_FF00, 32'd0, 1);
    cur = "clear_dbz";   run_op(2'd1, 32'd3, 32'd4, 0);

    cur = "flush_calc";  flush_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 10);
    cur = "after_flush"; run_op(2'd0, 32'hFFFF_FFFF, 32'd9, 0);
    cur = "flush_fixup"; flush_op(2'd2, 32'hFFFF_0000, 32'd3, 33);

    cur = "flush_start_idle";
    flush = 1'b1; start = 1'b1; op = 2'd0; a = 32'd2; b = 32'd3;
    tick();
    flush = 1'b0; start = 1'b0;
    check("busy", busy, 1'b0);
    check("done", done, 1'b0);
    tick();
    check("busy_late", busy, 1'b0);

    cur = "poke_calc";   run_op(2'd3, 32'hDEAD_BEEF, 32'h0000_1234, 5);
    cur = "poke_done";   run_op(2'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 34);

    cur = "reset_mid";
    op = 2'd2; a = 32'h8765_4321; b = 32'd77; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst = 1'b1; start = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9;
    tick();
    rst = 1'b0; start = 1'b0;
    check("busy", busy, 1'b0);
    check("done", done, 1'b0);
    check("hi", hi, '0);
    check("lo", lo, '0);
    check("dbz", dbz, 1'b0);
    tick();
    check("busy_late", busy, 1'b0);
    check("done_late", done, 1'b0);
    prev_hi = '0;
    prev_lo = '0;

    for (int i = 0; i < 50; i++) begin
      logic [1:0] ro;
      int         pk;
      ro = 2'($urandom_range(0, 3));
      pk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 34) : 0;
      cur = $sformatf("rand%0d_op%0d", i, ro);
      run_op(ro, pick(), pick(), pk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
